// File: rtl/fpdiv_ctrl.sv
// Sequencing controller for the Goldschmidt divider datapath.
// Walks the shared multiplier through initial approximation, the N/D
// iterations and the remainder product, then holds done until ack.
module fpdiv_ctrl #(
  parameter int unsigned ITER = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       rmode_in,
  input  logic       abort,
  input  logic       ack,
  output logic [1:0] sel_muxa,
  output logic [1:0] sel_muxb,
  output logic       enA,
  output logic       enB,
  output logic       enC,
  output logic       enR,
  output logic       rMode,
  output logic       busy,
  output logic       done,
  output logic [2:0] iter
);

  localparam logic [2:0] ITER_L = 3'(ITER);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DIA,
    S_XIA,
    S_NK,
    S_DK,
    S_REM,
    S_DONE
  } state_t;

  state_t     state;
  state_t     state_next;
  logic       rmode_next;
  logic [2:0] iter_next;

  // State, rounding mode and iteration counter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
      rMode <= 1'b0;
      iter  <= '0;
    end else begin
      state <= state_next;
      rMode <= rmode_next;
      iter  <= iter_next;
    end
  end

  // Next-state logic and Moore decode of selects/enables, with abort override.
  always_comb begin
    state_next = state;
    rmode_next = rMode;
    iter_next  = iter;
    sel_muxa   = 2'b00;
    sel_muxb   = 2'b00;
    enA        = 1'b0;
    enB        = 1'b0;
    enC        = 1'b0;
    enR        = 1'b0;
    done       = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (start && !abort) begin
          state_next = S_DIA;
          rmode_next = rmode_in;
          iter_next  = '0;
        end
      end
      S_DIA: begin
        sel_muxa   = 2'b10;
        sel_muxb   = 2'b00;
        enA        = 1'b1;
        enC        = 1'b1;
        state_next = S_XIA;
      end
      S_XIA: begin
        sel_muxa   = 2'b10;
        sel_muxb   = 2'b01;
        enB        = 1'b1;
        state_next = S_NK;
        iter_next  = 3'd1;
      end
      S_NK: begin
        sel_muxa = 2'b00;
        sel_muxb = 2'b10;
        enB      = 1'b1;
        // The last iteration goes straight to REM: D is not needed again.
        if (iter < ITER_L) state_next = S_DK;
        else               state_next = S_REM;
      end
      S_DK: begin
        sel_muxa   = 2'b00;
        sel_muxb   = 2'b11;
        enA        = 1'b1;
        enC        = 1'b1;
        state_next = S_NK;
        iter_next  = iter + 3'd1;
      end
      S_REM: begin
        sel_muxa   = 2'b01;
        sel_muxb   = 2'b10;
        enR        = 1'b1;
        state_next = S_DONE;
        iter_next  = '0;
      end
      S_DONE: begin
        done = 1'b1;
        if (ack) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase

    // Abort beats every other transition and blocks writes in its own cycle.
    if (abort && state != S_IDLE) begin
      state_next = S_IDLE;
      iter_next  = '0;
      enA        = 1'b0;
      enB        = 1'b0;
      enC        = 1'b0;
      enR        = 1'b0;
    end
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_fpdiv_ctrl.sv
// Directed bench for fpdiv_ctrl: ITER=3 and ITER=1 instances, checked cycle by cycle.
module tb_fpdiv_ctrl;

  logic clock = 1'b0;
  logic reset, start, start1, rmode_in, abort, ack, ack1;

  logic [1:0] ma3, mb3, ma1, mb1;
  logic       a3, b3, c3, r3, rm3, bz3, dn3;
  logic       a1, b1, c1, r1, rm1, bz1, dn1;
  logic [2:0] it3, it1;

  int checks = 0;
  int failures = 0;

  // {muxa, muxb, enA, enB, enC, enR, busy, done}
  localparam logic [9:0] P_IDLE = 10'b00_00_0000_0_0;
  localparam logic [9:0] P_DIA  = 10'b10_00_1010_1_0;
  localparam logic [9:0] P_XIA  = 10'b10_01_0100_1_0;
  localparam logic [9:0] P_NK   = 10'b00_10_0100_1_0;
  localparam logic [9:0] P_DK   = 10'b00_11_1010_1_0;
  localparam logic [9:0] P_REM  = 10'b01_10_0001_1_0;
  localparam logic [9:0] P_DONE = 10'b00_00_0000_1_1;
  localparam logic [9:0] P_NKAB = 10'b00_10_0000_1_0;
  localparam logic [9:0] P_DIAB = 10'b10_00_0000_1_0;

  fpdiv_ctrl #(.ITER(3)) dut (
    .clock(clock), .reset(reset), .start(start), .rmode_in(rmode_in),
    .abort(abort), .ack(ack), .sel_muxa(ma3), .sel_muxb(mb3),
    .enA(a3), .enB(b3), .enC(c3), .enR(r3), .rMode(rm3),
    .busy(bz3), .done(dn3), .iter(it3)
  );

  fpdiv_ctrl #(.ITER(1)) dut1 (
    .clock(clock), .reset(reset), .start(start1), .rmode_in(rmode_in),
    .abort(abort), .ack(ack1), .sel_muxa(ma1), .sel_muxb(mb1),
    .enA(a1), .enB(b1), .enC(c1), .enR(r1), .rMode(rm1),
    .busy(bz1), .done(dn1), .iter(it1)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [9:0] act, input logic [9:0] exp,
                     input logic [2:0] ai, input int ei, input logic ar, input logic er);
    checks++;
    assert (act === exp) else begin
      failures++;
      $error("FAIL %s outputs: got %b expected %b", tag, act, exp);
    end
    if (ei >= 0) begin
      checks++;
      assert (ai === 3'(ei)) else begin
        failures++;
        $error("FAIL %s iter: got %0d expected %0d", tag, ai, ei);
      end
    end
    checks++;
    assert (ar === er) else begin
      failures++;
      $error("FAIL %s rMode: got %b expected %b", tag, ar, er);
    end
  endtask

  task automatic k3(input string tag, input logic [9:0] exp, input int ei, input logic er);
    chk({"i3 ", tag}, {ma3, mb3, a3, b3, c3, r3, bz3, dn3}, exp, it3, ei, rm3, er);
  endtask

  task automatic k1(input string tag, input logic [9:0] exp, input int ei, input logic er);
    chk({"i1 ", tag}, {ma1, mb1, a1, b1, c1, r1, bz1, dn1}, exp, it1, ei, rm1, er);
  endtask

  logic [9:0] pat3 [1:13];
  int         itx3 [1:13];
  logic [9:0] pat1 [1:6];
  int         itx1 [1:6];

  initial begin
    pat3 = '{P_DIA, P_XIA, P_NK, P_DK, P_NK, P_DK, P_NK, P_REM,
             P_DONE, P_DONE, P_DONE, P_DONE, P_IDLE};
    itx3 = '{0, 0, 1, 1, 2, 2, 3, -1, 0, 0, 0, 0, 0};
    pat1 = '{P_DIA, P_XIA, P_NK, P_REM, P_DONE, P_IDLE};
    itx1 = '{0, 0, 1, -1, 0, 0};

    reset = 1'b1; start = 1'b0; start1 = 1'b0; rmode_in = 1'b0;
    abort = 1'b0; ack = 1'b0; ack1 = 1'b0;

    // Reset values, then idle five cycles
    repeat (3) tick;
    k3("reset", P_IDLE, 0, 1'b0);
    k1("reset", P_IDLE, 0, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick;
      k3($sformatf("idle%0d", i), P_IDLE, 0, 1'b0);
    end

    // Full ITER=3 division, start pulses in NK (c3) and DONE (c9) ignored, ack in c12
    rmode_in = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    rmode_in = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      k3($sformatf("run c%0d", k), pat3[k], itx3[k], 1'b1);
      start = (k == 3 || k == 9);
      ack   = (k == 12);
      if (k < 13) tick;
    end
    start = 1'b0;
    ack = 1'b0;

    // ITER=1: no DK, done at cycle 5
    rmode_in = 1'b0;
    start1 = 1'b1;
    tick;
    start1 = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      k1($sformatf("one c%0d", k), pat1[k], itx1[k], 1'b0);
      ack1 = (k == 5);
      if (k < 6) tick;
    end
    ack1 = 1'b0;
    k3("idle during i1", P_IDLE, 0, 1'b1);

    // Abort in cycle 5 (NK), restart at edge 6
    rmode_in = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    k3("ab c1", P_DIA, 0, 1'b1);
    tick; k3("ab c2", P_XIA, 0, 1'b1);
    tick; k3("ab c3", P_NK, 1, 1'b1);
    tick; k3("ab c4", P_DK, 1, 1'b1);
    tick; k3("ab c5", P_NK, 2, 1'b1);
    abort = 1'b1;
    #1;
    k3("ab c5 gated", P_NKAB, 2, 1'b1);
    tick;
    abort = 1'b0;
    k3("ab c6", P_IDLE, 0, 1'b1);
    start = 1'b1;
    tick;
    start = 1'b0;
    k3("ab c7 restart", P_DIA, 0, 1'b1);
    abort = 1'b1;
    #1;
    k3("ab c7 gated", P_DIAB, 0, 1'b1);
    tick;
    k3("ab c8", P_IDLE, 0, 1'b1);
    start = 1'b1;
    tick;
    k3("abort blocks start", P_IDLE, 0, 1'b1);
    start = 1'b0;
    abort = 1'b0;

    // Reset mid-operation with ack/start high
    rmode_in = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    k3("rs c1", P_DIA, 0, 1'b1);
    tick; tick; tick;
    k3("rs c4", P_DK, 1, 1'b1);
    reset = 1'b1; ack = 1'b1; start = 1'b1;
    tick;
    k3("rs after", P_IDLE, 0, 1'b0);
    ack = 1'b0;
    tick;
    k3("rs held", P_IDLE, 0, 1'b0);
    reset = 1'b0;
    tick;
    k3("rs released", P_DIA, 0, 1'b1);
    start = 1'b0;
    abort = 1'b1;
    tick;
    abort = 1'b0;
    k3("rs end", P_IDLE, 0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
